// File: rtl/stepper_step_gen_pkg.sv
// Shared definitions for the stepper step generator: FSM encodings and fixed constants.
package stepper_step_gen_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_HIGH  = 2'd2;
    localparam logic [1:0] ST_LOW   = 2'd3;

    localparam int   MIN_PERIOD = 2;
    localparam logic DIR_FWD    = 1'b1;

endpackage

// File: rtl/stepper_step_gen_step_channel.sv
// One step/direction channel: move FSM, phase counter, step counter.
// Optional signed position counter when POSITION_COUNTER_EN is defined.
module step_channel
    import stepper_step_gen_pkg::*;
#(
    parameter int PERIOD_W = 32,
    parameter int STEPS_W  = 16,
    parameter int POS_W    = 32
) (
    input  logic                clk,
    input  logic                reset_reset_n,
    input  logic                i_start,
    input  logic [PERIOD_W-1:0] i_period,
    input  logic [STEPS_W-1:0]  i_steps,
    input  logic                i_dir,
    input  logic                i_abort,
    output logic                o_step,
    output logic                o_dir,
    output logic                o_busy,
    output logic                o_done
`ifdef POSITION_COUNTER_EN
    ,
    output logic [POS_W-1:0]    o_position
`endif
);

    logic [1:0]          r_state;
    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] r_cnt;
    logic [STEPS_W-1:0]  r_left;
    logic                r_dir;
    logic                r_done;

    logic [PERIOD_W-1:0] w_period;
    logic [PERIOD_W-1:0] w_half;

    assign w_period = (i_period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : i_period;
    assign w_half   = r_period >> 1;

    // Abort overrides whatever transition the FSM would otherwise take.
    always_ff @(posedge clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state  <= ST_IDLE;
            r_period <= '0;
            r_cnt    <= '0;
            r_left   <= '0;
            r_dir    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state  <= ST_SETUP;
                        r_period <= w_period;
                        r_left   <= i_steps;
                        r_dir    <= i_dir;
                    end
                end
                ST_SETUP: begin
                    if (r_left == '0) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_HIGH;
                        r_cnt   <= w_half;
                    end
                end
                ST_HIGH: begin
                    if (r_cnt == PERIOD_W'(1)) begin
                        r_state <= ST_LOW;
                        r_cnt   <= r_period - w_half;
                    end else begin
                        r_cnt <= r_cnt - PERIOD_W'(1);
                    end
                end
                ST_LOW: begin
                    if (r_cnt == PERIOD_W'(1)) begin
                        r_left <= r_left - STEPS_W'(1);
                        if (r_left == STEPS_W'(1)) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_HIGH;
                            r_cnt   <= w_half;
                        end
                    end else begin
                        r_cnt <= r_cnt - PERIOD_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (r_state != ST_IDLE && i_abort) begin
                r_state <= ST_IDLE;
                r_done  <= 1'b1;
            end
        end
    end

    assign o_step = (r_state == ST_HIGH);
    assign o_busy = (r_state != ST_IDLE);
    assign o_dir  = r_dir;
    assign o_done = r_done;

`ifdef POSITION_COUNTER_EN
    logic [POS_W-1:0] r_pos;
    logic             w_step_rise;

    // A step rises on exactly the edges that move the FSM into HIGH.
    assign w_step_rise = !i_abort &&
                         ((r_state == ST_SETUP && r_left != '0) ||
                          (r_state == ST_LOW && r_cnt == PERIOD_W'(1) && r_left != STEPS_W'(1)));

    always_ff @(posedge clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_pos <= '0;
        end else if (w_step_rise) begin
            r_pos <= (r_dir == DIR_FWD) ? r_pos + POS_W'(1) : r_pos - POS_W'(1);
        end
    end

    assign o_position = r_pos;
`endif

endmodule

// File: rtl/stepper_step_gen.sv
// Multi-channel stepper step/direction generator: command decode and ready mux over step_channel.
// Define POSITION_COUNTER_EN to add the per-channel signed position output.
module stepper_step_gen
    import stepper_step_gen_pkg::*;
#(
    parameter int  NUM_CH   = 4,
    parameter int  PERIOD_W = 32,
    parameter int  STEPS_W  = 16,
    parameter int  POS_W    = 32,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset_reset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [CH_W-1:0]          cmd_chan,
    input  logic [PERIOD_W-1:0]      cmd_period,
    input  logic [STEPS_W-1:0]       cmd_steps,
    input  logic                     cmd_dir,
    input  logic [NUM_CH-1:0]        abort,
    output logic [NUM_CH-1:0]        step,
    output logic [NUM_CH-1:0]        dir,
    output logic [NUM_CH-1:0]        busy,
    output logic [NUM_CH-1:0]        done
`ifdef POSITION_COUNTER_EN
    ,
    output logic [NUM_CH*POS_W-1:0]  position
`endif
);

    logic [NUM_CH-1:0] w_accept;
    logic              w_sel_idle;
    logic              w_sel_abort;
    logic              w_chan_ok;

    // Out-of-range channel numbers select nothing, so they never look ready.
    always_comb begin
        w_sel_idle  = 1'b0;
        w_sel_abort = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cmd_chan == CH_W'(i)) begin
                w_sel_idle  = !busy[i];
                w_sel_abort = abort[i];
            end
        end
    end

    assign w_chan_ok = (32'(cmd_chan) < 32'(NUM_CH));
    assign cmd_ready = w_chan_ok && w_sel_idle && !w_sel_abort;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_accept[g] = cmd_valid && cmd_ready && (cmd_chan == CH_W'(g));

        step_channel #(
            .PERIOD_W (PERIOD_W),
            .STEPS_W  (STEPS_W),
            .POS_W    (POS_W)
        ) u_ch (
            .clk           (clk),
            .reset_reset_n (reset_reset_n),
            .i_start       (w_accept[g]),
            .i_period      (cmd_period),
            .i_steps       (cmd_steps),
            .i_dir         (cmd_dir),
            .i_abort       (abort[g]),
            .o_step        (step[g]),
            .o_dir         (dir[g]),
            .o_busy        (busy[g]),
            .o_done        (done[g])
`ifdef POSITION_COUNTER_EN
            ,
            .o_position    (position[g*POS_W +: POS_W])
`endif
        );
    end

endmodule

// File: tb/tb_stepper_step_gen.sv
// Directed self-checking bench for stepper_step_gen; checks position when POSITION_COUNTER_EN is defined.
module tb_stepper_step_gen;

    logic         clk;
    logic         reset_reset_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_chan;
    logic [31:0]  cmd_period;
    logic [15:0]  cmd_steps;
    logic         cmd_dir;
    logic [3:0]   abort;
    logic [3:0]   step;
    logic [3:0]   dir;
    logic [3:0]   busy;
    logic [3:0]   done;

    logic         cmd_valid2;
    logic         cmd_ready2;
    logic [1:0]   cmd_chan2;
    logic [2:0]   abort2;
    logic [2:0]   step2;
    logic [2:0]   dir2;
    logic [2:0]   busy2;
    logic [2:0]   done2;

`ifdef POSITION_COUNTER_EN
    logic [127:0] position;
    logic [95:0]  position2;
`endif

    int tests_run;
    int tests_failed;
    int exp_pos [4];

    stepper_step_gen dut (
        .clk           (clk),
        .reset_reset_n (reset_reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_chan      (cmd_chan),
        .cmd_period    (cmd_period),
        .cmd_steps     (cmd_steps),
        .cmd_dir       (cmd_dir),
        .abort         (abort),
        .step          (step),
        .dir           (dir),
        .busy          (busy),
        .done          (done)
`ifdef POSITION_COUNTER_EN
        ,
        .position      (position)
`endif
    );

    // Three-channel instance so that an out-of-range channel number is representable.
    stepper_step_gen #(.NUM_CH(3)) dut3 (
        .clk           (clk),
        .reset_reset_n (reset_reset_n),
        .cmd_valid     (cmd_valid2),
        .cmd_ready     (cmd_ready2),
        .cmd_chan      (cmd_chan2),
        .cmd_period    (cmd_period),
        .cmd_steps     (cmd_steps),
        .cmd_dir       (cmd_dir),
        .abort         (abort2),
        .step          (step2),
        .dir           (dir2),
        .busy          (busy2),
        .done          (done2)
`ifdef POSITION_COUNTER_EN
        ,
        .position      (position2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit exp_step(input int k, input int p, input int n);
        return (k >= 2) && (k < 2 + n * p) && (((k - 2) % p) < (p / 2));
    endfunction

    function automatic bit exp_busy(input int k, input int p, input int n);
        return (k >= 1) && (k < 2 + n * p);
    endfunction

    function automatic bit exp_done(input int k, input int p, input int n);
        return k == 2 + n * p;
    endfunction

    task automatic check_position(input int ch, input string name);
`ifdef POSITION_COUNTER_EN
        tests_run++;
        if ($signed(position[ch*32 +: 32]) !== exp_pos[ch]) begin
            tests_failed++;
            $display("[TB] FAIL %s position ch%0d: got %0d expected %0d", name, ch,
                     $signed(position[ch*32 +: 32]), exp_pos[ch]);
        end
`endif
    endtask

    // Leaves the bench one cycle after the accept edge (cycle T+1).
    task automatic send_cmd(input int ch, input int p, input int n, input bit d, input string name);
        cmd_chan   = 2'(ch);
        cmd_period = 32'(p);
        cmd_steps  = 16'(n);
        cmd_dir    = d;
        cmd_valid  = 1'b1;
        #1;
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL %s cmd_ready: got %b expected 1", name, cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_move(input int ch, input int p, input int n, input bit d, input string name);
        int pe;
        int last;
        pe   = (p < 2) ? 2 : p;
        last = 2 + n * pe + 2;
        send_cmd(ch, p, n, d, name);
        for (int k = 1; k <= last; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            tests_run++;
            if (step[ch] !== exp_step(k, pe, n) || busy[ch] !== exp_busy(k, pe, n) ||
                done[ch] !== exp_done(k, pe, n) || dir[ch] !== d) begin
                tests_failed++;
                $display("[TB] FAIL %s T+%0d step/busy/done/dir: got %b%b%b%b expected %b%b%b%b",
                         name, k, step[ch], busy[ch], done[ch], dir[ch],
                         exp_step(k, pe, n), exp_busy(k, pe, n), exp_done(k, pe, n), d);
            end
        end
        exp_pos[ch] += d ? n : -n;
        check_position(ch, name);
    endtask

    task automatic test_reset();
        reset_reset_n = 1'b0;
        cmd_valid     = 1'b0;
        cmd_chan      = 2'd0;
        cmd_period    = 32'd0;
        cmd_steps     = 16'd0;
        cmd_dir       = 1'b0;
        abort         = 4'd0;
        cmd_valid2    = 1'b0;
        cmd_chan2     = 2'd0;
        abort2        = 3'd0;
        for (int i = 0; i < 4; i++) exp_pos[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({step, dir, busy, done} !== 16'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_hold outputs: got %h expected 0000", {step, dir, busy, done});
        end
        #3 reset_reset_n = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if ({step, dir, busy, done} !== 16'h0 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_release outputs/ready: got %h/%b expected 0000/1",
                     {step, dir, busy, done}, cmd_ready);
        end
        check_position(0, "reset");
        check_position(3, "reset");
    endtask

    task automatic test_basic_forward();
        run_move(0, 4, 3, 1'b1, "fwd_p4_n3");
    endtask

    task automatic test_odd_reverse();
        run_move(1, 5, 2, 1'b0, "rev_p5_n2");
    endtask

    task automatic test_clamp_zero();
        run_move(2, 0, 1, 1'b1, "clamp_p0_n1");
        run_move(2, 3, 0, 1'b1, "zero_steps");
    endtask

    task automatic test_abort();
        send_cmd(0, 10, 100, 1'b1, "abort_move");
        for (int k = 2; k <= 22; k++) begin
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (step[0] !== 1'b1 || busy[0] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL abort_pre step/busy: got %b%b expected 11", step[0], busy[0]);
        end
        abort = 4'b0001;
        @(posedge clk);
        #1;
        abort = 4'b0000;
        tests_run++;
        if (step[0] !== 1'b0 || busy[0] !== 1'b0 || done[0] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL abort_stop step/busy/done: got %b%b%b expected 001",
                     step[0], busy[0], done[0]);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_after done/busy: got %b%b expected 00", done[0], busy[0]);
        end
        exp_pos[0] += 3;
        check_position(0, "abort");
        abort      = 4'b0100;
        cmd_chan   = 2'd2;
        cmd_period = 32'd4;
        cmd_steps  = 16'd1;
        cmd_valid  = 1'b1;
        #1;
        tests_run++;
        if (cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_with_cmd cmd_ready: got %b expected 0", cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        abort     = 4'b0000;
        tests_run++;
        if (busy[2] !== 1'b0 || done[2] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_idle busy/done: got %b%b expected 00", busy[2], done[2]);
        end
    endtask

    task automatic test_concurrent();
        send_cmd(0, 6, 2, 1'b1, "conc_ch0");
        cmd_chan   = 2'd0;
        cmd_valid  = 1'b1;
        #1;
        tests_run++;
        if (cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL busy_ch_ready: got %b expected 0", cmd_ready);
        end
        cmd_chan   = 2'd3;
        cmd_period = 32'd3;
        cmd_steps  = 16'd2;
        cmd_dir    = 1'b0;
        #1;
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL other_ch_ready: got %b expected 1", cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int k = 2; k <= 16; k++) begin
            if (k > 2) begin
                @(posedge clk);
                #1;
            end
            tests_run++;
            if (step[0] !== exp_step(k, 6, 2) || busy[0] !== exp_busy(k, 6, 2) ||
                done[0] !== exp_done(k, 6, 2) || dir[0] !== 1'b1 ||
                step[3] !== exp_step(k - 1, 3, 2) || busy[3] !== exp_busy(k - 1, 3, 2) ||
                done[3] !== exp_done(k - 1, 3, 2) || dir[3] !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL concurrent T+%0d ch0 sbdd=%b%b%b%b exp %b%b%b1 ch3 sbdd=%b%b%b%b exp %b%b%b0",
                         k, step[0], busy[0], done[0], dir[0],
                         exp_step(k, 6, 2), exp_busy(k, 6, 2), exp_done(k, 6, 2),
                         step[3], busy[3], done[3], dir[3],
                         exp_step(k - 1, 3, 2), exp_busy(k - 1, 3, 2), exp_done(k - 1, 3, 2));
            end
        end
        exp_pos[0] += 2;
        exp_pos[3] -= 2;
        check_position(0, "concurrent");
        check_position(3, "concurrent");
    endtask

    task automatic test_out_of_range();
        cmd_valid2 = 1'b1;
        cmd_chan2  = 2'd3;
        #1;
        tests_run++;
        if (cmd_ready2 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL chan_out_of_range ready: got %b expected 0", cmd_ready2);
        end
        cmd_valid2 = 1'b0;
        cmd_chan2  = 2'd2;
        #1;
        tests_run++;
        if (cmd_ready2 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL chan_last_valid ready: got %b expected 1", cmd_ready2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        int bad;
        bad = 0;
        send_cmd(1, 8, 5, 1'b1, "reset_move");
        for (int k = 2; k <= 4; k++) begin
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (step[1] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset step: got %b expected 1", step[1]);
        end
        #3 reset_reset_n = 1'b0;
        #1;
        tests_run++;
        if ({step, dir, busy, done} !== 16'h0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset outputs: got %h expected 0000", {step, dir, busy, done});
        end
        for (int i = 0; i < 4; i++) exp_pos[i] = 0;
        check_position(1, "async_reset");
        #2 reset_reset_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (done !== 4'h0 || busy !== 4'h0 || step !== 4'h0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL post_reset activity: got %0d active cycles expected 0", bad);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic_forward();
        test_odd_reverse();
        test_clamp_zero();
        test_abort();
        test_concurrent();
        test_out_of_range();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
